// File: rtl/dlsc_pcie_cmdsplit_be.sv
// dlsc_pcie_cmdsplit_be
//   Splits one byte-granular command (byte address + byte length 1..4096) into
//   DW-aligned PCIe sub-commands. Each chunk carries a DW count plus first/last
//   byte enables. A chunk never exceeds the runtime max payload and never
//   crosses a 4 KB boundary. Optionally, chunks are aligned to max payload
//   boundaries.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_*             command handshake (ready/valid), addr, len, align, meta
//   max_size         runtime max payload code (0=128 .. 5+=4096 bytes)
//   out_*            chunk handshake (ready/valid), DW-aligned addr, DW length
//                    (minus OUT_SUB), first/last byte enables, meta, last flag
module dlsc_pcie_cmdsplit_be #(
  parameter int ADDR     = 32,
  parameter int LEN      = 10,
  parameter int OUT_SUB  = 0,
  parameter int MAX_SIZE = 512,
  parameter int META     = 1,
  parameter int REGISTER = 1
) (
  input  logic            clk,
  input  logic            rst,

  output logic            in_ready,
  input  logic            in_valid,
  input  logic [ADDR-1:0] in_addr,
  input  logic [12:0]     in_len,
  input  logic            in_align,
  input  logic [META-1:0] in_meta,

  input  logic [2:0]      max_size,

  input  logic            out_ready,
  output logic            out_valid,
  output logic [ADDR-1:0] out_addr,
  output logic [LEN-1:0]  out_len,
  output logic [3:0]      out_first_be,
  output logic [3:0]      out_last_be,
  output logic [META-1:0] out_meta,
  output logic            out_last
);

  localparam int          DWA    = ADDR - 2;
  localparam logic [10:0] CAP_DW = 11'(MAX_SIZE / 4);

  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Effective payload limit in DWs (one cycle behind max_size)
  // ---------------------------------------------------------------------------
  logic [10:0] dec_dw;
  logic [10:0] max_lim_dw;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (default or full case); a missing path would infer a latch.
  always_comb begin
    case (max_size)
      3'd0:    dec_dw = 11'd32;
      3'd1:    dec_dw = 11'd64;
      3'd2:    dec_dw = 11'd128;
      3'd3:    dec_dw = 11'd256;
      3'd4:    dec_dw = 11'd512;
      default: dec_dw = 11'd1024;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_lim_dw <= 11'd32;
    end else begin
      max_lim_dw <= (dec_dw < CAP_DW) ? dec_dw : CAP_DW;
    end
  end

  // ---------------------------------------------------------------------------
  // Split state
  // ---------------------------------------------------------------------------
  logic [DWA-1:0]  dw_addr;
  logic [10:0]     rem_dw;
  logic [1:0]      start_off;
  logic [1:0]      end_off;
  logic            align_r;
  logic            first_r;
  logic [META-1:0] meta_r;

  // Offset of the final byte relative to the DW-aligned start (max 4098).
  logic [12:0] end_byte;
  assign end_byte = 13'(in_addr[1:0]) + in_len - 13'd1;

  logic accept;
  logic advance;
  assign accept   = in_valid && in_ready;
  assign in_ready = (state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Current chunk
  // ---------------------------------------------------------------------------
  logic [10:0] to4k;
  logic [10:0] lim;
  logic [10:0] chunk;
  logic        chunk_last;
  logic [3:0]  fmask;
  logic [3:0]  lmask;
  logic [3:0]  c_first_be;
  logic [3:0]  c_last_be;
  logic [LEN-1:0] c_len;

  assign to4k = 11'd1024 - {1'b0, dw_addr[9:0]};
  // With alignment, the limit shrinks to reach the next max-size boundary;
  // once aligned, the subtracted term is zero and chunks are full size.
  assign lim  = align_r ? (max_lim_dw - ({1'b0, dw_addr[9:0]} & (max_lim_dw - 11'd1)))
                        : max_lim_dw;

  always_comb begin
    chunk = rem_dw;
    if (lim < chunk)  chunk = lim;
    if (to4k < chunk) chunk = to4k;
  end

  assign chunk_last = (chunk == rem_dw);
  assign c_len      = LEN'(chunk - 11'(OUT_SUB));

  always_comb begin
    fmask = first_r    ? (4'hF << start_off)         : 4'hF;
    lmask = chunk_last ? (4'hF >> (2'd3 - end_off))  : 4'hF;
    // PCIe encodes a single-DW transfer entirely in first_be.
    if (chunk == 11'd1) begin
      c_first_be = fmask & lmask;
      c_last_be  = 4'h0;
    end else begin
      c_first_be = fmask;
      c_last_be  = lmask;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)              state_nxt = S_SPLIT;
      S_SPLIT: if (advance && chunk_last) state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the split datapath is reset along with control so a reset mid-command
  // leaves nothing that could be mistaken for a pending chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dw_addr   <= '0;
      rem_dw    <= '0;
      start_off <= '0;
      end_off   <= '0;
      align_r   <= 1'b0;
      first_r   <= 1'b0;
      meta_r    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dw_addr   <= in_addr[ADDR-1:2];
        rem_dw    <= end_byte[12:2] + 11'd1;
        start_off <= in_addr[1:0];
        end_off   <= end_byte[1:0];
        align_r   <= in_align;
        first_r   <= 1'b1;
        meta_r    <= in_meta;
      end else if (advance) begin
        dw_addr   <= dw_addr + DWA'(chunk);
        rem_dw    <= rem_dw - chunk;
        first_r   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  if (REGISTER != 0) begin : g_reg
    // The register refills whenever it is empty or being drained this cycle.
    assign advance = (state == S_SPLIT) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid    <= 1'b0;
        out_addr     <= '0;
        out_len      <= '0;
        out_first_be <= 4'h0;
        out_last_be  <= 4'h0;
        out_meta     <= '0;
        out_last     <= 1'b0;
      end else if (advance) begin
        out_valid    <= 1'b1;
        out_addr     <= {dw_addr, 2'b00};
        out_len      <= c_len;
        out_first_be <= c_first_be;
        out_last_be  <= c_last_be;
        out_meta     <= meta_r;
        out_last     <= chunk_last;
      end else if (out_ready) begin
        out_valid    <= 1'b0;
      end
    end
  end else begin : g_comb
    assign advance = (state == S_SPLIT) && out_ready;

    // Outputs are forced to zero while idle so nothing stale is visible.
    always_comb begin
      out_valid    = 1'b0;
      out_addr     = '0;
      out_len      = '0;
      out_first_be = 4'h0;
      out_last_be  = 4'h0;
      out_meta     = '0;
      out_last     = 1'b0;
      if (state == S_SPLIT) begin
        out_valid    = 1'b1;
        out_addr     = {dw_addr, 2'b00};
        out_len      = c_len;
        out_first_be = c_first_be;
        out_last_be  = c_last_be;
        out_meta     = meta_r;
        out_last     = chunk_last;
      end
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_cmdsplit_be.sv
// tb_dlsc_pcie_cmdsplit_be
//   Two instances: d0 = registered outputs, MAX_SIZE 4096, OUT_SUB 0;
//   d1 = combinational outputs, MAX_SIZE 512, OUT_SUB 1.
//   Directed vectors from a table, hand-timed latency and reset sequences, and
//   random commands against a byte-level reference model.
`timescale 1ns/1ps
module tb_dlsc_pcie_cmdsplit_be;

  typedef struct packed {
    logic [31:0] addr;
    logic [9:0]  len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [3:0]  meta;
    logic        last;
  } chunk_t;

  typedef struct {
    int           d;
    logic [31:0]  addr;
    int           len;
    bit           align;
    logic [2:0]   ms;
    logic [3:0]   meta;
    int           n;
    chunk_t [2:0] c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_ready     [2];
  logic        in_valid     [2];
  logic [31:0] in_addr      [2];
  logic [12:0] in_len       [2];
  logic        in_align     [2];
  logic [3:0]  in_meta      [2];
  logic [2:0]  max_size     [2];
  logic        out_ready    [2];
  logic        out_valid    [2];
  logic [31:0] out_addr     [2];
  logic [9:0]  out_len      [2];
  logic [3:0]  out_first_be [2];
  logic [3:0]  out_last_be  [2];
  logic [3:0]  out_meta     [2];
  logic        out_last     [2];

  bit rdy_rand [2];
  bit rdy_val  [2];

  int checks   = 0;
  int failures = 0;

  chunk_t exp_q0[$];
  chunk_t exp_q1[$];

  always #5 clk = ~clk;

  dlsc_pcie_cmdsplit_be #(
    .ADDR(32), .LEN(10), .OUT_SUB(0), .MAX_SIZE(4096), .META(4), .REGISTER(1)
  ) u_d0 (
    .clk(clk), .rst(rst),
    .in_ready(in_ready[0]), .in_valid(in_valid[0]), .in_addr(in_addr[0]),
    .in_len(in_len[0]), .in_align(in_align[0]), .in_meta(in_meta[0]),
    .max_size(max_size[0]),
    .out_ready(out_ready[0]), .out_valid(out_valid[0]), .out_addr(out_addr[0]),
    .out_len(out_len[0]), .out_first_be(out_first_be[0]),
    .out_last_be(out_last_be[0]), .out_meta(out_meta[0]), .out_last(out_last[0])
  );

  dlsc_pcie_cmdsplit_be #(
    .ADDR(32), .LEN(10), .OUT_SUB(1), .MAX_SIZE(512), .META(4), .REGISTER(0)
  ) u_d1 (
    .clk(clk), .rst(rst),
    .in_ready(in_ready[1]), .in_valid(in_valid[1]), .in_addr(in_addr[1]),
    .in_len(in_len[1]), .in_align(in_align[1]), .in_meta(in_meta[1]),
    .max_size(max_size[1]),
    .out_ready(out_ready[1]), .out_valid(out_valid[1]), .out_addr(out_addr[1]),
    .out_len(out_len[1]), .out_first_be(out_first_be[1]),
    .out_last_be(out_last_be[1]), .out_meta(out_meta[1]), .out_last(out_last[1])
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void push_exp(input int d, input chunk_t c);
    if (d == 0) exp_q0.push_back(c);
    else        exp_q1.push_back(c);
  endfunction

  function automatic chunk_t pop_exp(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic chunk_t mk(input logic [31:0] a, input logic [9:0] l,
                                input logic [3:0] f, input logic [3:0] lb,
                                input logic [3:0] m, input logic last);
    chunk_t c;
    c.addr = a; c.len = l; c.fbe = f; c.lbe = lb; c.meta = m; c.last = last;
    return c;
  endfunction

  function automatic int max_of(input int d);
    return (d == 0) ? 4096 : 512;
  endfunction

  function automatic int osub_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // Byte enables of the DW at 'base' for the byte range [s, e).
  function automatic logic [3:0] be_of(input longint base, input longint s, input longint e);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ((base + i) >= s) && ((base + i) < e);
    return b;
  endfunction

  // Reference model: walk the DW-rounded byte range, cutting at whichever comes
  // first of the 4 KB boundary, the payload limit (or the next limit-aligned
  // boundary when aligning), and the end of the transfer.
  function automatic void model_push(input int d, input logic [31:0] a, input int len,
                                     input bit al, input int ms, input logic [3:0] m);
    longint lim, cur, nxt, bnd, b4k, s, e, s_end;
    int     dw;
    chunk_t c;
    lim = longint'(128) << ((ms > 5) ? 5 : ms);
    if (lim > max_of(d)) lim = max_of(d);
    s     = longint'(a);
    e     = s + len;
    cur   = (s / 4) * 4;
    s_end = ((e + 3) / 4) * 4;
    while (cur < s_end) begin
      b4k = (cur / 4096 + 1) * 4096;
      bnd = al ? (cur / lim + 1) * lim : cur + lim;
      nxt = s_end;
      if (b4k < nxt) nxt = b4k;
      if (bnd < nxt) nxt = bnd;
      dw     = int'((nxt - cur) / 4);
      c.addr = cur[31:0];
      c.len  = 10'(dw - osub_of(d));
      c.fbe  = be_of(cur, s, e);
      c.lbe  = (dw == 1) ? 4'h0 : be_of(nxt - 4, s, e);
      c.meta = m;
      c.last = (nxt == s_end);
      push_exp(d, c);
      cur = nxt;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a command once in_ready is seen; returns #1 after the accept edge.
  // max_size changes only while the DUT is idle.
  task automatic send_cmd(input int d, input logic [31:0] a, input int len,
                          input bit al, input logic [2:0] ms, input logic [3:0] m);
    int n = 0;
    while (!in_ready[d] && n < 20000) begin
      cyc(1);
      n++;
    end
    if (!in_ready[d]) begin
      check($sformatf("accept_timeout_d%0d", d), 64'(in_ready[d]), 64'd1);
    end else begin
      in_valid[d] = 1'b1;
      in_addr[d]  = a;
      in_len[d]   = 13'(len);
      in_align[d] = al;
      in_meta[d]  = m;
      max_size[d] = ms;
      cyc(1);
      in_valid[d] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (exp_size(d) != 0 && n < 20000) begin
      cyc(1);
      n++;
    end
    check($sformatf("drain_d%0d", d), 64'(exp_size(d)), 64'd0);
    cyc(1);
  endtask

  task automatic random_phase(input int d, input int n);
    logic [31:0] a;
    int          len;
    bit          al;
    logic [2:0]  ms;
    logic [3:0]  m;
    for (int i = 0; i < n; i++) begin
      a = $urandom & 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) a = (a & ~32'hFFF) | (32'hFFF - $urandom_range(0, 64));
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 16);
        1:       len = 4096;
        default: len = $urandom_range(1, 4096);
      endcase
      al = 1'($urandom_range(0, 1));
      ms = 3'($urandom_range(0, 7));
      m  = 4'($urandom);
      model_push(d, a, len, al, int'(ms), m);
      send_cmd(d, a, len, al, ms, m);
    end
    wait_drain(d);
  endtask

  // ---------------------------------------------------------------------------
  // out_ready drivers and output monitors
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_tb
    initial begin
      out_ready[g] = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        out_ready[g] = rdy_rand[g] ? ($urandom_range(0, 3) != 0) : rdy_val[g];
      end
    end

    initial begin
      chunk_t cur_c;
      chunk_t prev_c;
      logic   prev_stall;
      prev_stall = 1'b0;
      prev_c     = '0;
      forever begin
        @(negedge clk);
        cur_c = mk(out_addr[g], out_len[g], out_first_be[g], out_last_be[g],
                   out_meta[g], out_last[g]);
        if (rst) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall)
            check($sformatf("hold_d%0d", g), {out_valid[g], cur_c}, {1'b1, prev_c});
          if (out_valid[g] && out_ready[g]) begin
            if (exp_size(g) == 0)
              check($sformatf("spurious_chunk_d%0d", g), 64'(out_valid[g]), 64'd0);
            else
              check($sformatf("chunk_d%0d", g), cur_c, pop_exp(g));
          end
          prev_stall = out_valid[g] && !out_ready[g];
          prev_c     = cur_c;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t vecs [9];

    vecs[0] = '{d:0, addr:32'h1000, len:256,  align:0, ms:3'd0, meta:4'h5, n:2, c:'0};
    vecs[0].c[0] = mk(32'h1000, 10'd32, 4'hF, 4'hF, 4'h5, 1'b0);
    vecs[0].c[1] = mk(32'h1080, 10'd32, 4'hF, 4'hF, 4'h5, 1'b1);
    vecs[1] = '{d:0, addr:32'hFF2, len:16,    align:0, ms:3'd2, meta:4'hA, n:2, c:'0};
    vecs[1].c[0] = mk(32'hFF0,  10'd4,  4'hC, 4'hF, 4'hA, 1'b0);
    vecs[1].c[1] = mk(32'h1000, 10'd1,  4'h3, 4'h0, 4'hA, 1'b1);
    vecs[2] = '{d:0, addr:32'h2040, len:512,  align:1, ms:3'd1, meta:4'h3, n:3, c:'0};
    vecs[2].c[0] = mk(32'h2040, 10'd48, 4'hF, 4'hF, 4'h3, 1'b0);
    vecs[2].c[1] = mk(32'h2100, 10'd64, 4'hF, 4'hF, 4'h3, 1'b0);
    vecs[2].c[2] = mk(32'h2200, 10'd16, 4'hF, 4'hF, 4'h3, 1'b1);
    vecs[3] = '{d:0, addr:32'h3, len:1,       align:0, ms:3'd2, meta:4'h1, n:1, c:'0};
    vecs[3].c[0] = mk(32'h0,    10'd1,  4'h8, 4'h0, 4'h1, 1'b1);
    vecs[4] = '{d:1, addr:32'h3, len:1,       align:0, ms:3'd2, meta:4'h2, n:1, c:'0};
    vecs[4].c[0] = mk(32'h0,    10'd0,  4'h8, 4'h0, 4'h2, 1'b1);
    vecs[5] = '{d:0, addr:32'h1, len:4096,    align:0, ms:3'd5, meta:4'h7, n:2, c:'0};
    vecs[5].c[0] = mk(32'h0,    10'd0,  4'hE, 4'hF, 4'h7, 1'b0);
    vecs[5].c[1] = mk(32'h1000, 10'd1,  4'h1, 4'h0, 4'h7, 1'b1);
    vecs[6] = '{d:1, addr:32'hFF2, len:16,    align:0, ms:3'd2, meta:4'h9, n:2, c:'0};
    vecs[6].c[0] = mk(32'hFF0,  10'd3,  4'hC, 4'hF, 4'h9, 1'b0);
    vecs[6].c[1] = mk(32'h1000, 10'd0,  4'h3, 4'h0, 4'h9, 1'b1);
    vecs[7] = '{d:1, addr:32'h2040, len:512,  align:1, ms:3'd1, meta:4'h4, n:3, c:'0};
    vecs[7].c[0] = mk(32'h2040, 10'd47, 4'hF, 4'hF, 4'h4, 1'b0);
    vecs[7].c[1] = mk(32'h2100, 10'd63, 4'hF, 4'hF, 4'h4, 1'b0);
    vecs[7].c[2] = mk(32'h2200, 10'd15, 4'hF, 4'hF, 4'h4, 1'b1);
    vecs[8] = '{d:1, addr:32'h0, len:1024,    align:0, ms:3'd5, meta:4'h6, n:2, c:'0};
    vecs[8].c[0] = mk(32'h0,    10'd127, 4'hF, 4'hF, 4'h6, 1'b0);
    vecs[8].c[1] = mk(32'h200,  10'd127, 4'hF, 4'hF, 4'h6, 1'b1);

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_addr[d] = '0; in_len[d] = '0; in_align[d] = 1'b0;
      in_meta[d]  = '0;   max_size[d] = 3'd0;
      rdy_rand[d] = 1'b0; rdy_val[d]  = 1'b1;
    end
    cyc(3);

    // Reset state of both flavours.
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_in_ready_d%0d", d),  64'(in_ready[d]),  64'd1);
      check($sformatf("reset_out_valid_d%0d", d), 64'(out_valid[d]), 64'd0);
      check($sformatf("reset_outputs_d%0d", d),
            64'(mk(out_addr[d], out_len[d], out_first_be[d], out_last_be[d],
                   out_meta[d], out_last[d])), 64'd0);
    end
    rst = 1'b0;
    cyc(2);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < vecs[i].n; j++) push_exp(vecs[i].d, vecs[i].c[j]);
      send_cmd(vecs[i].d, vecs[i].addr, vecs[i].len, vecs[i].align, vecs[i].ms, vecs[i].meta);
      wait_drain(vecs[i].d);
    end

    // Latency and in_ready return, registered flavour.
    push_exp(0, mk(32'h40, 10'd1, 4'hF, 4'h0, 4'h0, 1'b1));
    send_cmd(0, 32'h40, 4, 1'b0, 3'd2, 4'h0);
    check("lat_d0_valid_after_accept", 64'(out_valid[0]), 64'd0);
    check("lat_d0_ready_after_accept", 64'(in_ready[0]),  64'd0);
    cyc(1);
    check("lat_d0_valid_2nd_edge",     64'(out_valid[0]), 64'd1);
    check("lat_d0_ready_after_load",   64'(in_ready[0]),  64'd1);
    wait_drain(0);

    // Latency and in_ready return, combinational flavour.
    push_exp(1, mk(32'h40, 10'd0, 4'hF, 4'h0, 4'h0, 1'b1));
    send_cmd(1, 32'h40, 4, 1'b0, 3'd2, 4'h0);
    check("lat_d1_valid_after_accept", 64'(out_valid[1]), 64'd1);
    check("lat_d1_ready_after_accept", 64'(in_ready[1]),  64'd0);
    cyc(1);
    check("lat_d1_ready_after_hs",     64'(in_ready[1]),  64'd1);
    check("lat_d1_valid_after_hs",     64'(out_valid[1]), 64'd0);
    wait_drain(1);

    // Random commands, back-to-back, with random backpressure.
    for (int d = 0; d < 2; d++) begin
      rdy_rand[d] = 1'b1;
      random_phase(d, 40);
      rdy_rand[d] = 1'b0;
    end

    // Reset in the middle of a long stalled/trickling command.
    for (int d = 0; d < 2; d++) begin
      rdy_rand[d] = 1'b1;
      model_push(d, 32'h5000, 4096, 1'b0, 0, 4'hB);
      send_cmd(d, 32'h5000, 4096, 1'b0, 3'd0, 4'hB);
      cyc(12);
      rst = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      rdy_rand[d] = 1'b0;
      rdy_val[d]  = 1'b1;
      cyc(2);
      rst = 1'b0;
      check($sformatf("midrst_in_ready_d%0d", d),  64'(in_ready[d]),  64'd1);
      check($sformatf("midrst_out_valid_d%0d", d), 64'(out_valid[d]), 64'd0);
      // Any chunk appearing now is flagged by the monitor.
      cyc(20);
      check($sformatf("midrst_quiet_d%0d", d), 64'(out_valid[d]), 64'd0);
      // Normal operation resumes.
      model_push(d, 32'h1000, 256, 1'b0, 0, 4'h5);
      send_cmd(d, 32'h1000, 256, 1'b0, 3'd0, 4'h5);
      wait_drain(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
